// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: multi-channel PWM with shadowed duties and edge/center-aligned counting
module pwm_multi_ch #(
  parameter int WIDTH = 10,
  parameter int NCH = 4,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [WIDTH-1:0] wr_duty,
  output logic [NCH-1:0]   PWM_sig,
  output logic             period_end,
  output logic             upd_pending
);
  localparam logic [WIDTH-1:0] MAX = '1;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] shadow [NCH];
  logic [WIDTH-1:0] active [NCH];
  logic dir, amode, acc, boundary, reload;
  assign acc = wr_en && ({1'b0, wr_ch} < (CHW+1)'(NCH));
  assign boundary = amode ? (dir && cnt == WIDTH'(1)) : (cnt == MAX);
  assign reload = !en || boundary;
  // period counter: holds at 0 while disabled, restarts from 0 at each boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      dir <= 1'b0;
    end else if (reload) begin
      cnt <= '0;
      dir <= 1'b0;
    end else if (!amode || !dir) begin
      cnt <= (amode && cnt == MAX) ? MAX - WIDTH'(1) : cnt + WIDTH'(1);
      dir <= amode && cnt == MAX;
    end else begin
      cnt <= cnt - WIDTH'(1);
    end
  end
  // shadow duties take writes; active duties and mode reload at boundaries or while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      amode <= 1'b0;
    end else begin
      if (acc) shadow[wr_ch] <= wr_duty;
      for (int i = 0; i < NCH; i++) active[i] <= reload ? shadow[i] : active[i];
      amode <= reload ? mode : amode;
    end
  end
  // registered outputs compare the pre-edge count against the pre-edge active duty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PWM_sig <= '0;
      period_end <= 1'b0;
      upd_pending <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) PWM_sig[i] <= en && (cnt < active[i]);
      period_end <= en && boundary;
      upd_pending <= acc || (upd_pending && !reload);
    end
  end
endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: scoreboard bench measuring per-period length and per-channel high time
module tb_pwm_multi_ch;
  localparam int W = 10;
  localparam int N = 5;
  localparam int CW = 3;
  typedef struct packed {
    logic [31:0] len;
    logic [N-1:0][31:0] h;
  } win_t;
  logic clk = 1'b0;
  logic rst_n, en, mode, wr_en;
  logic [CW-1:0] wr_ch;
  logic [W-1:0] wr_duty;
  logic [N-1:0] PWM_sig;
  logic period_end, upd_pending;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hc [N];
  win_t q [$];

  pwm_multi_ch #(.WIDTH(W), .NCH(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_duty(wr_duty), .PWM_sig(PWM_sig),
    .period_end(period_end), .upd_pending(upd_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int len, input int a, input int b, input int c, input int d, input int e);
    win_t w;
    w.len = len;
    w.h[0] = a;
    w.h[1] = b;
    w.h[2] = c;
    w.h[3] = d;
    w.h[4] = e;
    q.push_back(w);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int d);
    wr_en = 1'b1;
    wr_ch = CW'(ch);
    wr_duty = W'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_pe();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_end && n < 3000);
    if (!period_end) begin
      checks++;
      failures++;
      $display("FAIL wait_pe: no period_end within %0d cycles at %0t", n, $time);
    end
  endtask

  // monitor: accumulate one period window and score it when period_end is seen
  initial begin
    win_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !en) begin
        cyc = 0;
        for (int c = 0; c < N; c++) hc[c] = 0;
      end else begin
        cyc++;
        for (int c = 0; c < N; c++) hc[c] += int'(PWM_sig[c]);
        if (period_end) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_period: len %0d with no expected window", cyc);
          end else begin
            e = q.pop_front();
            chk("win_len", cyc, int'(e.len));
            for (int c = 0; c < N; c++) chk($sformatf("win_high_ch%0d", c), hc[c], int'(e.h[c]));
          end
          cyc = 0;
          for (int c = 0; c < N; c++) hc[c] = 0;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    mode = 1'b0;
    wr_en = 1'b0;
    wr_ch = '0;
    wr_duty = '0;
    tick(2);
    chk("rst_pwm", int'(PWM_sig), 0);
    chk("rst_pe", int'(period_end), 0);
    chk("rst_upd", int'(upd_pending), 0);
    rst_n = 1'b1;
    wr(0, 2);
    wr(1, 0);
    wr(2, 1023);
    chk("idle_upd_set", int'(upd_pending), 1);
    tick(1);
    chk("idle_upd_clr", int'(upd_pending), 0);
    chk("idle_pwm", int'(PWM_sig), 0);
    push(1024, 2, 0, 1023, 0, 0);
    push(1024, 2, 0, 1023, 0, 0);
    push(1024, 100, 0, 1023, 0, 0);
    push(1024, 500, 0, 1023, 0, 0);
    en = 1'b1;
    wait_pe();
    wr(0, 100);
    chk("upd_after_wr", int'(upd_pending), 1);
    wait_pe();
    chk("upd_clr_boundary", int'(upd_pending), 0);
    tick(300);
    wr(0, 500);
    chk("upd_mid_period", int'(upd_pending), 1);
    wait_pe();
    chk("upd_clr_boundary2", int'(upd_pending), 0);
    wait_pe();
    push(1024, 500, 0, 1023, 0, 0);
    push(1024, 500, 0, 1023, 0, 0);
    push(1024, 500, 50, 1023, 0, 0);
    wr(5, 7);
    chk("bad_ch_ignored_upd", int'(upd_pending), 0);
    tick(1022);
    wr(1, 50);
    chk("boundary_wr_pe", int'(period_end), 1);
    chk("boundary_wr_upd", int'(upd_pending), 1);
    wait_pe();
    chk("upd_clr_next", int'(upd_pending), 0);
    wait_pe();
    push(1024, 500, 50, 1023, 0, 0);
    push(2046, 19, 99, 2045, 0, 0);
    push(1024, 10, 50, 1023, 0, 0);
    mode = 1'b1;
    wr(0, 10);
    wait_pe();
    tick(500);
    mode = 1'b0;
    wait_pe();
    wait_pe();
    tick(500);
    en = 1'b0;
    tick(1);
    chk("en_drop_pwm", int'(PWM_sig), 0);
    chk("en_drop_pe", int'(period_end), 0);
    tick(3);
    push(1024, 10, 50, 1023, 0, 0);
    en = 1'b1;
    wait_pe();
    tick(500);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", int'(PWM_sig), 0);
    chk("async_rst_pe", int'(period_end), 0);
    chk("async_rst_upd", int'(upd_pending), 0);
    push(1024, 0, 0, 0, 0, 0);
    tick(3);
    rst_n = 1'b1;
    wait_pe();
    tick(2);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
